// File: rtl/tmp_seq_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmp_seq_mc
// Purpose  : Multi-channel temperature-sensor conversion sequencer. It steps
//            the analog front end through precharge / small-diode / big-diode
//            phases. The comparator decision from each big-diode phase drives
//            one charge-pump pulse, and the decisions are accumulated into a
//            code. Channels are served round-robin from an enable mask.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            en                    - run enable (looked at in IDLE / OUTPUT)
//            ch_en[NCH]            - channel enable mask (looked at on selection)
//            cmp                   - comparator decision
//            PI1..PD, preChrg      - analog switch controls
//            src, snk              - charge-pump source / sink pulses
//            ch_sel[NCH]           - one-hot active channel, zero when idle
//            result, result_ch     - last conversion code and its channel
//            valid, busy           - result strobe, sequencer active
// Revision : 1.0  initial release
// ============================================================================
module tmp_seq_mc #(
    parameter  int NCH       = 4,
    parameter  int RW        = 8,
    parameter  int NCONV     = 63,
    parameter  int PRE_CYC   = 11,
    parameter  int DIODE_CYC = 2,
    parameter  int BIG_CYC   = 3,
    localparam int C_CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [NCH-1:0]   ch_en,
    input  logic             cmp,
    output logic             PI1,
    output logic             PI2,
    output logic             PII1,
    output logic             PII2,
    output logic             PA,
    output logic             PB,
    output logic             PC,
    output logic             PD,
    output logic             preChrg,
    output logic             src,
    output logic             snk,
    output logic [NCH-1:0]   ch_sel,
    output logic [RW-1:0]    result,
    output logic [C_CHW-1:0] result_ch,
    output logic             valid,
    output logic             busy
);

    localparam int c_len_max = (PRE_CYC > DIODE_CYC) ?
                               ((PRE_CYC > BIG_CYC) ? PRE_CYC : BIG_CYC) :
                               ((DIODE_CYC > BIG_CYC) ? DIODE_CYC : BIG_CYC);
    localparam int c_tw = (c_len_max > 1) ? $clog2(c_len_max) : 1;
    localparam logic [RW:0] c_nconv = (RW+1)'(NCONV);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_BLANK_D = 3'd2,
        S_DIODE   = 3'd3,
        S_BLANK_B = 3'd4,
        S_BIG     = 3'd5,
        S_PUMP    = 3'd6,
        S_OUTPUT  = 3'd7
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_tw-1:0]  r_cnt, w_cnt_nxt;
    logic [RW-1:0]    r_iter, w_iter_nxt;
    logic [RW-1:0]    r_acc, w_acc_nxt;
    logic             r_dec, w_dec_nxt;
    // Index of the channel most recently selected; round-robin starts above it.
    logic [C_CHW-1:0] r_cur, w_cur_nxt;

    logic             w_sel_found;
    logic [C_CHW-1:0] w_sel_ch;

    logic             w_pi, w_pii, w_pa, w_pre, w_src, w_snk;
    logic [NCH-1:0]   w_ch_sel;

    // ------------------------------------------------------------------------
    // Round-robin pick: the enabled channel with the smallest forward
    // distance from r_cur (distance 0 = the channel right after r_cur).
    // The current channel itself has distance NCH-1, so a lone enabled
    // channel is picked again.
    // ------------------------------------------------------------------------
    always_comb begin
        int best_d;
        int d;
        best_d      = NCH;
        d           = 0;
        w_sel_ch    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_en[i]) begin
                d = (i + NCH - int'(r_cur) - 1) % NCH;
                if (d < best_d) begin
                    best_d   = d;
                    w_sel_ch = C_CHW'(i);
                end
            end
        end
        w_sel_found = (best_d < NCH);
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_iter_nxt  = r_iter;
        w_acc_nxt   = r_acc;
        w_dec_nxt   = r_dec;
        w_cur_nxt   = r_cur;
        case (r_state)
            S_IDLE: begin
                if (en && w_sel_found) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = '0;
                    w_cur_nxt   = w_sel_ch;
                end
            end
            S_PRE: begin
                if (r_cnt == c_tw'(PRE_CYC - 1)) begin
                    w_state_nxt = S_BLANK_D;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BLANK_D: begin
                w_state_nxt = S_DIODE;
                w_cnt_nxt   = '0;
            end
            S_DIODE: begin
                if (r_cnt == c_tw'(DIODE_CYC - 1)) begin
                    w_state_nxt = S_BLANK_B;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BLANK_B: begin
                w_state_nxt = S_BIG;
                w_cnt_nxt   = '0;
            end
            S_BIG: begin
                if (r_cnt == c_tw'(BIG_CYC - 1)) begin
                    // Only the settled comparator value at the end of the
                    // big-diode phase counts.
                    w_dec_nxt   = cmp;
                    w_state_nxt = S_PUMP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PUMP: begin
                if (r_dec && (r_acc != {RW{1'b1}})) begin
                    w_acc_nxt = r_acc + 1'b1;
                end
                w_iter_nxt = r_iter + 1'b1;
                if (({1'b0, r_iter} + 1'b1) == c_nconv) begin
                    w_state_nxt = S_OUTPUT;
                end else begin
                    w_state_nxt = S_BLANK_D;
                end
            end
            S_OUTPUT: begin
                w_acc_nxt  = '0;
                w_iter_nxt = '0;
                if (en && w_sel_found) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = '0;
                    w_cur_nxt   = w_sel_ch;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, so the registered outputs line up
    // exactly with the state they belong to.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pi  = 1'b0;
        w_pii = 1'b0;
        w_pa  = 1'b0;
        w_pre = 1'b0;
        w_src = 1'b0;
        w_snk = 1'b0;
        case (w_state_nxt)
            S_PRE:   w_pre = 1'b1;
            S_DIODE: w_pii = 1'b1;
            S_BIG:   w_pi  = 1'b1;
            S_PUMP: begin
                w_pa  = 1'b1;
                w_src = w_dec_nxt;
                w_snk = ~w_dec_nxt;
            end
            default: begin
            end
        endcase
        w_ch_sel = (w_state_nxt != S_IDLE) ? (NCH'(1) << w_cur_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_iter    <= '0;
            r_acc     <= '0;
            r_dec     <= 1'b0;
            r_cur     <= C_CHW'(NCH - 1);
            PI1       <= 1'b0;
            PI2       <= 1'b0;
            PII1      <= 1'b0;
            PII2      <= 1'b0;
            PA        <= 1'b0;
            PB        <= 1'b0;
            PC        <= 1'b0;
            PD        <= 1'b0;
            preChrg   <= 1'b0;
            src       <= 1'b0;
            snk       <= 1'b0;
            ch_sel    <= '0;
            result    <= '0;
            result_ch <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_iter    <= w_iter_nxt;
            r_acc     <= w_acc_nxt;
            r_dec     <= w_dec_nxt;
            r_cur     <= w_cur_nxt;
            PI1       <= w_pi;
            PI2       <= w_pi;
            PII1      <= w_pii;
            PII2      <= w_pii;
            PA        <= w_pa;
            PB        <= w_pre;
            PC        <= w_pre;
            PD        <= w_pre;
            preChrg   <= w_pre;
            src       <= w_src;
            snk       <= w_snk;
            ch_sel    <= w_ch_sel;
            valid     <= (w_state_nxt == S_OUTPUT);
            busy      <= (w_state_nxt != S_IDLE);
            // Result is loaded with the final accumulator value on entry to
            // OUTPUT so that it is already valid alongside the strobe.
            if (w_state_nxt == S_OUTPUT) begin
                result    <= w_acc_nxt;
                result_ch <= w_cur_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmp_seq_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tmp_seq_mc
// Purpose  : Self-checking bench for tmp_seq_mc. A negedge monitor records
//            every conversion, and the expected code, channel and pulse counts
//            come from the conversion timing formula and the round-robin rule.
// Revision : 1.0  initial release
// ============================================================================
module tb_tmp_seq_mc;

    localparam int NCH      = 4;
    localparam int RW       = 8;
    localparam int NCONV    = 63;
    localparam int PRE      = 11;
    localparam int DIO      = 2;
    localparam int BIG      = 3;
    localparam int STEP     = DIO + BIG + 3;
    localparam int CONV_LEN = PRE + NCONV * STEP + 1;
    localparam int SAT      = (1 << RW) - 1;
    localparam int HMAX     = 40000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic           cmp = 1'b0;
    logic           PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg, src, snk;
    logic [NCH-1:0] ch_sel;
    logic [RW-1:0]  result;
    logic [1:0]     result_ch;
    logic           valid, busy;

    tmp_seq_mc #(
        .NCH(NCH), .RW(RW), .NCONV(NCONV),
        .PRE_CYC(PRE), .DIODE_CYC(DIO), .BIG_CYC(BIG)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .ch_en(ch_en), .cmp(cmp),
        .PI1(PI1), .PI2(PI2), .PII1(PII1), .PII2(PII2), .PA(PA),
        .PB(PB), .PC(PC), .PD(PD), .preChrg(preChrg),
        .src(src), .snk(snk), .ch_sel(ch_sel),
        .result(result), .result_ch(result_ch), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int             res;
        int             ch;
        int             exp_res;
        int             exp_ch;
        int             srcs;
        int             snks;
        int             ones;
        int             lat;
        logic [NCH-1:0] sel;
    } rec_t;

    rec_t rec_q[$];

    // cmp stimulus modes: 0 constant 0, 1 constant 1,
    // 2 alternate per decision sample starting with 1, 3 random every cycle
    int             cmp_mode = 1;
    logic           cmp_hist [0:HMAX-1];
    int             n = 0;
    logic           prev_pre = 1'b0;
    logic           prev_reset = 1'b1;
    logic [NCH-1:0] prev_mask = '0;
    logic           in_conv = 1'b0;
    int             conv_start = 0;
    int             src_cnt = 0;
    int             snk_cnt = 0;
    int             model_last = NCH - 1;
    int             exp_ch_cur = 0;
    logic [NCH-1:0] sel_at_start = '0;
    int             inv_viol = 0;
    int             spurious = 0;

    function automatic int rr(input int last, input logic [NCH-1:0] m);
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (last + k) % NCH;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor + cmp driver. Interval n is the time between posedge n and
    // posedge n+1; cmp set here is what the DUT samples at the end of n.
    always @(negedge clk) begin
        int   ones;
        int   t;
        int   base;
        rec_t r;
        n++;
        if (prev_reset) begin
            in_conv    = 1'b0;
            model_last = NCH - 1;
        end
        if (preChrg && !prev_pre) begin
            in_conv      = 1'b1;
            conv_start   = n;
            src_cnt      = 0;
            snk_cnt      = 0;
            exp_ch_cur   = rr(model_last, prev_mask);
            if (exp_ch_cur >= 0) model_last = exp_ch_cur;
            sel_at_start = ch_sel;
        end
        if (in_conv) begin
            src_cnt += int'(src);
            snk_cnt += int'(snk);
        end
        if (((PI1 | PI2) & (PII1 | PII2)) || (src & snk) || ((src | snk) & !PA)
            || (busy && !$onehot(ch_sel)) || (!busy && ch_sel != '0))
            inv_viol++;
        if (valid) begin
            if (!in_conv) begin
                spurious++;
            end else begin
                ones = 0;
                for (int i = 0; i < NCONV; i++) begin
                    t = conv_start + PRE + i * STEP + DIO + BIG + 1;
                    if (t < HMAX && cmp_hist[t] === 1'b1) ones++;
                end
                r.res     = int'(result);
                r.ch      = int'(result_ch);
                r.exp_res = (ones > SAT) ? SAT : ones;
                r.exp_ch  = exp_ch_cur;
                r.srcs    = src_cnt;
                r.snks    = snk_cnt;
                r.ones    = ones;
                r.lat     = n - conv_start + 1;
                r.sel     = sel_at_start;
                rec_q.push_back(r);
                in_conv = 1'b0;
            end
        end
        prev_pre   = preChrg;
        prev_reset = reset;
        prev_mask  = ch_en;
        base = conv_start + PRE + DIO + BIG + 1;
        case (cmp_mode)
            0: cmp = 1'b0;
            1: cmp = 1'b1;
            2: cmp = (in_conv && n >= base) ? ((((n - base) / STEP) % 2) == 0) : 1'b1;
            default: cmp = 1'($urandom % 2);
        endcase
        if (n < HMAX) cmp_hist[n] = cmp;
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        tick(2);
        reset = 1'b0;
        rec_q.delete();
    endtask

    task automatic wait_recs(input int k, input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (rec_q.size() >= k) break;
            tick(1);
        end
        ok = (rec_q.size() >= k);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; ch_en = 4'b1111;
        tick(2);
        total++;
        if ({PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg, src, snk, ch_sel,
             result, result_ch, valid, busy} !== '0)
            $display("FAIL reset_outputs: got busy=%0b ch_sel=%b result=%0d want all zero",
                     busy, ch_sel, result);
        else passed++;
        reset = 1'b0; en = 1'b0;
        tick(5);
        total++;
        if (busy !== 1'b0) $display("FAIL idle_en_low: busy=%0b want 0", busy); else passed++;
        en = 1'b1; ch_en = '0;
        tick(5);
        total++;
        if (busy !== 1'b0) $display("FAIL idle_mask_zero: busy=%0b want 0", busy); else passed++;
        en = 1'b0;
    endtask

    task automatic test_all_ones();
        bit ok;
        rec_t r;
        do_reset();
        cmp_mode = 1; ch_en = 4'b0001; en = 1'b1;
        tick(1);
        total++;
        if ({PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg, src, snk} !== 11'b00000111100
            || ch_sel !== 4'b0001)
            $display("FAIL precharge_entry: sw=%b ch_sel=%b want 00000111100/0001",
                     {PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg, src, snk}, ch_sel);
        else passed++;
        en = 1'b0;
        wait_recs(1, CONV_LEN + 20, ok);
        total++;
        if (!ok) $display("FAIL ones_timeout: records=%0d want 1", rec_q.size()); else passed++;
        if (ok) begin
            r = rec_q[0];
            total++;
            if (r.lat !== CONV_LEN || r.lat !== 516)
                $display("FAIL ones_latency: got %0d want %0d", r.lat, CONV_LEN);
            else passed++;
            total++;
            if (r.res !== r.exp_res || r.res !== 63)
                $display("FAIL ones_result: got %0d want %0d", r.res, r.exp_res);
            else passed++;
            total++;
            if (r.ch !== 0) $display("FAIL ones_channel: got %0d want 0", r.ch); else passed++;
            total++;
            if (r.srcs !== 63 || r.snks !== 0)
                $display("FAIL ones_pulses: src=%0d snk=%0d want 63/0", r.srcs, r.snks);
            else passed++;
        end
        tick(10);
        total++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 8'd63)
            $display("FAIL ones_hold: busy=%0b valid=%0b result=%0d want 0/0/63",
                     busy, valid, result);
        else passed++;
    endtask

    task automatic test_all_zero();
        bit ok;
        do_reset();
        cmp_mode = 0; ch_en = 4'b0001; en = 1'b1;
        tick(1);
        en = 1'b0;
        wait_recs(1, CONV_LEN + 20, ok);
        total++;
        if (!ok) $display("FAIL zero_timeout: records=%0d want 1", rec_q.size()); else passed++;
        if (ok) begin
            total++;
            if (rec_q[0].res !== 0 || rec_q[0].exp_res !== 0)
                $display("FAIL zero_result: got %0d want 0", rec_q[0].res);
            else passed++;
            total++;
            if (rec_q[0].snks !== 63 || rec_q[0].srcs !== 0)
                $display("FAIL zero_pulses: src=%0d snk=%0d want 0/63",
                         rec_q[0].srcs, rec_q[0].snks);
            else passed++;
        end
    endtask

    task automatic test_toggle();
        bit ok;
        do_reset();
        cmp_mode = 2; ch_en = 4'b0001; en = 1'b1;
        tick(1);
        en = 1'b0;
        wait_recs(1, CONV_LEN + 20, ok);
        total++;
        if (!ok) $display("FAIL toggle_timeout: records=%0d want 1", rec_q.size()); else passed++;
        if (ok) begin
            total++;
            if (rec_q[0].res !== 32 || rec_q[0].exp_res !== 32)
                $display("FAIL toggle_result: got %0d model %0d want 32",
                         rec_q[0].res, rec_q[0].exp_res);
            else passed++;
            total++;
            if (rec_q[0].srcs !== rec_q[0].ones || rec_q[0].snks !== NCONV - rec_q[0].ones)
                $display("FAIL toggle_pulses: src=%0d snk=%0d want %0d/%0d",
                         rec_q[0].srcs, rec_q[0].snks, rec_q[0].ones, NCONV - rec_q[0].ones);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int seq;
        do_reset();
        cmp_mode = 3; ch_en = 4'b1010; en = 1'b1;
        wait_recs(4, 4 * CONV_LEN + 50, ok);
        en = 1'b0;
        total++;
        if (!ok) $display("FAIL rr_timeout: records=%0d want 4", rec_q.size()); else passed++;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                seq = (i % 2 == 0) ? 1 : 3;
                total++;
                if (rec_q[i].ch !== seq || rec_q[i].exp_ch !== seq)
                    $display("FAIL rr_channel[%0d]: got %0d want %0d", i, rec_q[i].ch, seq);
                else passed++;
                total++;
                if (rec_q[i].sel !== (4'b0001 << seq))
                    $display("FAIL rr_ch_sel[%0d]: got %b want %b", i, rec_q[i].sel,
                             4'b0001 << seq);
                else passed++;
                total++;
                if (rec_q[i].res !== rec_q[i].exp_res)
                    $display("FAIL rr_result[%0d]: got %0d want %0d", i, rec_q[i].res,
                             rec_q[i].exp_res);
                else passed++;
            end
        end
        tick(CONV_LEN + 10);
    endtask

    task automatic test_random_mask();
        bit ok;
        int cyc;
        do_reset();
        cmp_mode = 3; ch_en = 4'($urandom_range(1, 15)); en = 1'b1;
        cyc = 0;
        while (rec_q.size() < 5 && cyc < 6 * CONV_LEN) begin
            tick(1);
            cyc++;
            if (cyc % 137 == 0) ch_en = 4'($urandom_range(1, 15));
        end
        en = 1'b0;
        ok = (rec_q.size() >= 5);
        total++;
        if (!ok) $display("FAIL rand_timeout: records=%0d want 5", rec_q.size()); else passed++;
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (rec_q[i].ch !== rec_q[i].exp_ch || rec_q[i].sel !== (4'b0001 << rec_q[i].exp_ch))
                    $display("FAIL rand_channel[%0d]: got %0d sel %b want %0d",
                             i, rec_q[i].ch, rec_q[i].sel, rec_q[i].exp_ch);
                else passed++;
                total++;
                if (rec_q[i].res !== rec_q[i].exp_res)
                    $display("FAIL rand_result[%0d]: got %0d want %0d", i, rec_q[i].res,
                             rec_q[i].exp_res);
                else passed++;
                total++;
                if (rec_q[i].srcs !== rec_q[i].ones || rec_q[i].lat !== CONV_LEN)
                    $display("FAIL rand_src_lat[%0d]: src=%0d lat=%0d want %0d/%0d", i,
                             rec_q[i].srcs, rec_q[i].lat, rec_q[i].ones, CONV_LEN);
                else passed++;
            end
        end
        tick(CONV_LEN + 10);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        do_reset();
        cmp_mode = 1; ch_en = 4'b0111; en = 1'b1;
        wait_recs(1, CONV_LEN + 20, ok);
        total++;
        if (!ok || rec_q[0].ch !== 0)
            $display("FAIL mid_first: records=%0d want first conversion on ch 0", rec_q.size());
        else passed++;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick(1);
            if (PI1 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) $display("FAIL mid_bigdiode_seen: PI1=%0b want 1", PI1); else passed++;
        reset = 1'b1;
        tick(1);
        total++;
        if ({PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg, src, snk, ch_sel, valid, busy} !== '0)
            $display("FAIL mid_reset_outputs: busy=%0b ch_sel=%b valid=%0b want zero",
                     busy, ch_sel, valid);
        else passed++;
        reset = 1'b0;
        wait_recs(2, CONV_LEN + 30, ok);
        en = 1'b0;
        total++;
        if (!ok) $display("FAIL mid_timeout: records=%0d want 2", rec_q.size()); else passed++;
        if (ok) begin
            total++;
            if (rec_q[1].ch !== 0 || rec_q[1].exp_ch !== 0)
                $display("FAIL mid_restart_channel: got %0d want 0", rec_q[1].ch);
            else passed++;
            total++;
            if (rec_q[1].res !== 63)
                $display("FAIL mid_restart_result: got %0d want 63", rec_q[1].res);
            else passed++;
        end
        tick(CONV_LEN + 10);
    endtask

    task automatic test_en_drop();
        bit ok;
        do_reset();
        cmp_mode = 3; ch_en = 4'b0011; en = 1'b1;
        wait_recs(1, CONV_LEN + 20, ok);
        total++;
        if (!ok) $display("FAIL endrop_timeout: records=%0d want 1", rec_q.size()); else passed++;
        tick(100);
        en = 1'b0;
        tick(2 * CONV_LEN);
        total++;
        if (rec_q.size() !== 2 || busy !== 1'b0)
            $display("FAIL endrop_count: records=%0d busy=%0b want 2/0", rec_q.size(), busy);
        else passed++;
        if (rec_q.size() >= 2) begin
            total++;
            if (rec_q[1].ch !== 1 || rec_q[1].res !== rec_q[1].exp_res)
                $display("FAIL endrop_last: ch=%0d res=%0d want 1/%0d", rec_q[1].ch,
                         rec_q[1].res, rec_q[1].exp_res);
            else passed++;
        end
    endtask

    task automatic test_invariants();
        total++;
        if (inv_viol !== 0) $display("FAIL invariants: violations=%0d want 0", inv_viol);
        else passed++;
        total++;
        if (spurious !== 0) $display("FAIL spurious_valid: count=%0d want 0", spurious);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zero();
        test_toggle();
        test_round_robin();
        test_random_mask();
        test_reset_mid();
        test_en_drop();
        test_invariants();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tmp_seq_mc.md
TMP_SEQ_MC -- requirements
Module: tmp_seq_mc

Interface
REQ-001 Parameter NCH, 4, number of sensor channels (1..8).
REQ-002 Parameter RW, 8, result/accumulator width.
REQ-003 Parameter NCONV, 63, pump decisions per conversion (1..2^RW-1).
REQ-004 Parameter PRE_CYC, 11, precharge phase length in cycles (>=1).
REQ-005 Parameter DIODE_CYC, 2, small-diode phase length in cycles (>=1).
REQ-006 Parameter BIG_CYC, 3, big-diode phase length in cycles (>=1).
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 en  in  1  run enable; sampled only in IDLE and OUTPUT.
REQ-010 ch_en  in  NCH  channel enable mask; sampled only at channel selection.
REQ-011 cmp  in  1  comparator decision from analog front end.
REQ-012 PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg  out  1 each  switch controls.
REQ-013 src, snk  out  1 each  charge-pump source/sink pulses.
REQ-014 ch_sel  out  NCH  one-hot active channel; all zero in IDLE.
REQ-015 result  out  RW  last conversion code; result_ch  out  clog2(NCH) (min 1)  its channel.
REQ-016 valid  out  1  one-cycle result strobe; busy  out  1  high in every state except IDLE.

Function
REQ-017 All outputs SHALL be registered Moore outputs; src/snk SHALL be registered, never combinational from cmp.
REQ-018 States: IDLE, PRECHARGE, BLANK_D, DIODE, BLANK_B, BIGDIODE, PUMP, OUTPUT.
REQ-019 IDLE: all switch/pump outputs 0; if en=1 and ch_en!=0 -> PRECHARGE next cycle with channel selected per REQ-027; else stay.
REQ-020 PRECHARGE: PRE_CYC cycles; preChrg=PB=PC=PD=1, others 0; then BLANK_D.
REQ-021 BLANK_D: 1 cycle, all switch outputs 0; then DIODE.
REQ-022 DIODE: DIODE_CYC cycles, PII1=PII2=1; then BLANK_B (1 cycle, all 0); then BIGDIODE.
REQ-023 BIGDIODE: BIG_CYC cycles, PI1=PI2=1; cmp captured into decision register on last BIGDIODE cycle only; then PUMP.
REQ-024 PUMP: 1 cycle; PA=1; src=dec, snk=~dec; acc+=dec; iter+=1; if iter reaches NCONV -> OUTPUT, else BLANK_D.
REQ-025 PI* and PII* SHALL never be high in the same cycle; src and snk SHALL never be high together; both 0 outside PUMP.
REQ-026 OUTPUT: 1 cycle; result<=acc, result_ch<=channel, valid=1; acc and iter cleared; if en=1 and ch_en!=0 -> PRECHARGE on next channel, else IDLE.
REQ-027 Channel selection: round-robin, first enabled channel strictly above the last converted index, wrapping NCH-1 -> 0; single enabled channel repeats.
REQ-028 Conversion length SHALL be PRE_CYC + NCONV*(DIODE_CYC+BIG_CYC+3) + 1 cycles (defaults: 516), PRECHARGE entry to OUTPUT inclusive.
REQ-029 acc SHALL saturate at 2^RW-1; never wraps.
REQ-030 en deasserted mid-conversion: current conversion completes with valid, then IDLE.
REQ-031 ch_en change mid-conversion (including disabling active channel): no effect until next selection.
REQ-032 result/result_ch SHALL hold between OUTPUT cycles.

Reset
REQ-033 reset=1 at a clock edge: state IDLE, all outputs 0, result=0, result_ch=0, acc=iter=0, last-channel pointer=NCH-1 (next selection starts at lowest enabled).
REQ-034 Reset mid-conversion SHALL discard the partial result; no valid emitted.

Verification
REQ-035 Defaults, ch_en=0001, en=1, cmp=1 -> valid 516 cycles after PRECHARGE entry, result=63, result_ch=0, 63 src pulses, 0 snk.
REQ-036 cmp=0 constant -> result=0, 63 snk pulses, 0 src pulses.
REQ-037 cmp toggling per BIGDIODE sample starting 1 -> result=32.
REQ-038 ch_en=1010, en=1 -> result_ch sequence 1,3,1,3; ch_sel one-hot matches each conversion.
REQ-039 reset pulsed during BIGDIODE -> outputs 0 next cycle, no valid, next conversion from channel 0 with acc=0.
REQ-040 en dropped mid-conversion -> exactly one further valid, then busy=0; assert REQ-025 invariants throughout all tests.
